// File: rtl/seq_pkg.sv
// Purpose : shared types, widths and ramp helpers for the rect pulse sequencer.
// Latency : n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: seq_state_e (phase encoding seen on out_phase), seq_cfg_t (config word),
//           CNT_W/AMP_W widths, saturating ramp_up/ramp_down helpers.
// Build option: SEQ_BURST_COUNT_EN adds the burst field to seq_cfg_t.
package seq_pkg;

   localparam int CNT_W = 16;
   localparam int AMP_W = 12;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DELAY = 3'd1,
      RISE  = 3'd2,
      HIGH  = 3'd3,
      FALL  = 3'd4,
      LOW   = 3'd5
   } seq_state_e;

   typedef struct packed {
      logic [CNT_W-1:0] td;
      logic [CNT_W-1:0] tr;
      logic [CNT_W-1:0] th;
      logic [CNT_W-1:0] tf;
      logic [CNT_W-1:0] tl;
      logic [AMP_W-1:0] amp;
      logic [AMP_W-1:0] rise_step;
      logic [AMP_W-1:0] fall_step;
      logic             periodic;
`ifdef SEQ_BURST_COUNT_EN
      logic [CNT_W-1:0] burst;
`endif
   } seq_cfg_t;

   // One extra bit of headroom so the sum can be compared against amp before truncation.
   function automatic logic [AMP_W-1:0] ramp_up(input logic [AMP_W-1:0] base,
                                                input logic [AMP_W-1:0] step,
                                                input logic [AMP_W-1:0] amp);
      logic [AMP_W:0] sum;
      sum = {1'b0, base} + {1'b0, step};
      if (sum > {1'b0, amp}) ramp_up = amp;
      else                   ramp_up = sum[AMP_W-1:0];
   endfunction

   // A set top bit after the subtraction means a borrow, i.e. the result went below 0.
   function automatic logic [AMP_W-1:0] ramp_down(input logic [AMP_W-1:0] base,
                                                  input logic [AMP_W-1:0] step);
      logic [AMP_W:0] diff;
      diff = {1'b0, base} - {1'b0, step};
      if (diff[AMP_W]) ramp_down = '0;
      else             ramp_down = diff[AMP_W-1:0];
   endfunction

endpackage

// File: rtl/rect_pulse_sequencer_if.sv
// Purpose : config load port of the sequencer (valid/ready + config word).
// Latency : n/a (bundle of wires).
// Backpressure: cfg_ready low while the sequencer is busy; a word transfers on cfg_valid & cfg_ready.
// Modports: master drives cfg_valid/cfg and observes cfg_ready; slave is the sequencer side.
interface rect_pulse_sequencer_if;

   logic              cfg_valid;
   logic              cfg_ready;
   seq_pkg::seq_cfg_t cfg;

   modport master (output cfg_valid, output cfg, input cfg_ready);
   modport slave  (input cfg_valid, input cfg, output cfg_ready);

endinterface

// File: rtl/seq_phase_timer.sv
// Purpose : loadable down-counter timing one sequencer phase.
// Latency : last_cycle_o is high during the final cycle of a phase loaded with len_i (len_i cycles total).
// Backpressure: none; reload and zero-length skipping are the parent's job.
// Ports: clk/rst_n, load_i (reload this cycle), len_i (phase length), last_cycle_o.
module seq_phase_timer
   import seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] len_i,
   output logic             last_cycle_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)              cnt_d = len_i;
      else if (cnt_q != '0)    cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign last_cycle_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/rect_pulse_sequencer.sv
// Purpose : drives a DAC code through delay/rise/high/fall/low of a trapezoidal pulse.
// Latency : first non-IDLE phase one cycle after start is sampled; stop reaches IDLE next cycle.
// Backpressure: cfg_ready only in IDLE, so the config is frozen for the whole run.
// Ports: clk, rst_n (async active-low), cfg_if (slave config port), start, stop,
//        out_level (DAC code), out_phase, busy, period_done, burst_left (SEQ_BURST_COUNT_EN only).
// Build option: SEQ_BURST_COUNT_EN limits periodic runs to cfg.burst periods (0 = unlimited).
module rect_pulse_sequencer
   import seq_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   rect_pulse_sequencer_if.slave cfg_if,
   input  logic                 start,
   input  logic                 stop,
   output logic [AMP_W-1:0]     out_level,
   output seq_state_e           out_phase,
   output logic                 busy,
   output logic                 period_done
`ifdef SEQ_BURST_COUNT_EN
   ,
   output logic [CNT_W-1:0]     burst_left
`endif
);

   seq_state_e       state_q, state_d;
   logic [AMP_W-1:0] level_q, level_d;
   seq_cfg_t         cfg_q;

   logic             last_cycle;
   logic             advance;
   logic             period_end;
   logic             run_on;
   logic [CNT_W-1:0] th_eff;
   logic [CNT_W-1:0] len;
   seq_state_e       target;
   seq_state_e       after_idle, after_delay, after_rise, after_high, after_fall, wrap_state;

   // Successor chain with zero-length phases folded away. IDLE here marks "end of period".
   // With tr..tl all zero, th is forced to 1 so a periodic loop always has a real phase.
   always_comb begin
      th_eff      = ({cfg_q.tr, cfg_q.th, cfg_q.tf, cfg_q.tl} == '0) ? CNT_W'(1) : cfg_q.th;
      after_fall  = (cfg_q.tl != '0) ? LOW  : IDLE;
      after_high  = (cfg_q.tf != '0) ? FALL : after_fall;
      after_rise  = (th_eff   != '0) ? HIGH : after_high;
      after_delay = (cfg_q.tr != '0) ? RISE : after_rise;
      after_idle  = (cfg_q.td != '0) ? DELAY : after_delay;
      // Periodic repeats skip DELAY; after_rise is never IDLE thanks to th_eff.
      wrap_state  = (cfg_q.tr != '0) ? RISE : after_rise;
   end

`ifdef SEQ_BURST_COUNT_EN
   logic [CNT_W-1:0] burst_left_q, burst_left_d;

   assign run_on = cfg_q.periodic &&
                   !((cfg_q.burst != '0) && (burst_left_q == CNT_W'(1)));

   always_comb begin
      burst_left_d = burst_left_q;
      if ((state_q == IDLE) && start && !stop)        burst_left_d = cfg_q.burst;
      else if (period_end && (burst_left_q != '0))    burst_left_d = burst_left_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) burst_left_q <= '0;
      else        burst_left_q <= burst_left_d;
   end

   assign burst_left = burst_left_q;
`else
   assign run_on = cfg_q.periodic;
`endif

   // Next state: advance on the last cycle of a phase (or on start from IDLE); stop overrides.
   always_comb begin
      state_d    = state_q;
      advance    = 1'b0;
      period_end = 1'b0;
      target     = IDLE;
      case (state_q)
         DELAY:   target = after_delay;
         RISE:    target = after_rise;
         HIGH:    target = after_high;
         FALL:    target = after_fall;
         default: target = IDLE;
      endcase
      if (state_q == IDLE) begin
         if (start && !stop) begin
            advance = 1'b1;
            state_d = after_idle;
         end
      end else if (last_cycle) begin
         advance = 1'b1;
         if (target == IDLE) begin
            period_end = 1'b1;
            state_d    = run_on ? wrap_state : IDLE;
         end else begin
            state_d = target;
         end
      end
      if (stop) state_d = IDLE;
   end

   // Level follows the next state. A ramp restarts from its entry value whenever the
   // phase is (re)entered, including a phase looping onto itself in periodic mode.
   always_comb begin
      level_d = '0;
      case (state_d)
         RISE: level_d = ramp_up((state_q == RISE && !advance) ? level_q : '0,
                                 cfg_q.rise_step, cfg_q.amp);
         HIGH: level_d = cfg_q.amp;
         FALL: level_d = ramp_down((state_q == FALL && !advance) ? level_q : cfg_q.amp,
                                   cfg_q.fall_step);
         default: level_d = '0;
      endcase
   end

   always_comb begin
      len = '0;
      case (state_d)
         DELAY:   len = cfg_q.td;
         RISE:    len = cfg_q.tr;
         HIGH:    len = th_eff;
         FALL:    len = cfg_q.tf;
         LOW:     len = cfg_q.tl;
         default: len = '0;
      endcase
   end

   seq_phase_timer u_timer (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (advance),
      .len_i        (len),
      .last_cycle_o (last_cycle)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         level_q <= '0;
         cfg_q   <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         if (cfg_if.cfg_valid && cfg_if.cfg_ready) cfg_q <= cfg_if.cfg;
      end
   end

   assign cfg_if.cfg_ready = (state_q == IDLE);
   assign out_level        = level_q;
   assign out_phase        = state_q;
   assign busy             = (state_q != IDLE);
   assign period_done      = period_end;

endmodule

// File: tb/tb_rect_pulse_sequencer.sv
module tb_rect_pulse_sequencer;
   import seq_pkg::*;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             stop;
   logic [AMP_W-1:0] out_level;
   seq_state_e       out_phase;
   logic             busy;
   logic             period_done;
`ifdef SEQ_BURST_COUNT_EN
   logic [CNT_W-1:0] burst_left;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   rect_pulse_sequencer_if cif ();

   rect_pulse_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_if      (cif),
      .start       (start),
      .stop        (stop),
      .out_level   (out_level),
      .out_phase   (out_phase),
      .busy        (busy),
      .period_done (period_done)
`ifdef SEQ_BURST_COUNT_EN
      ,
      .burst_left  (burst_left)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic seq_cfg_t mk_cfg(input int td, input int tr, input int th, input int tf,
                                       input int tl, input int amp, input int rs, input int fs,
                                       input logic per);
      seq_cfg_t c;
      c           = '0;
      c.td        = CNT_W'(td);
      c.tr        = CNT_W'(tr);
      c.th        = CNT_W'(th);
      c.tf        = CNT_W'(tf);
      c.tl        = CNT_W'(tl);
      c.amp       = AMP_W'(amp);
      c.rise_step = AMP_W'(rs);
      c.fall_step = AMP_W'(fs);
      c.periodic  = per;
      return c;
   endfunction

   // Stimulus drivers: entered and left on a falling edge.
   task automatic load_cfg(input seq_cfg_t c);
      cif.cfg_valid = 1'b1;
      cif.cfg       = c;
      @(negedge clk);
      cif.cfg_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (out_level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", out_level); end
      n_checks++;
      if (out_phase !== IDLE) begin n_fail++; $display("FAIL reset_phase: got %0d expected 0", out_phase); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++;
      if (period_done !== 1'b0) begin n_fail++; $display("FAIL reset_pd: got %b expected 0", period_done); end
      n_checks++;
      if (cif.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cif.cfg_ready); end
`ifdef SEQ_BURST_COUNT_EN
      n_checks++;
      if (burst_left !== '0) begin n_fail++; $display("FAIL reset_burst_left: got %0d expected 0", burst_left); end
`endif
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Test 1: one-shot trapezoid, full per-cycle trace.
   task automatic test_one_shot();
      int         exp_lvl [14] = '{0, 0, 25, 50, 75, 100, 100, 100, 100, 50, 0, 0, 0, 0};
      seq_state_e exp_ph  [14] = '{DELAY, DELAY, RISE, RISE, RISE, RISE, HIGH, HIGH, HIGH,
                                   FALL, FALL, LOW, LOW, LOW};
      load_cfg(mk_cfg(2, 4, 3, 2, 3, 100, 25, 50, 1'b0));
      pulse_start();
      for (int i = 0; i < 14; i++) begin
         n_checks++;
         if (out_level !== AMP_W'(exp_lvl[i])) begin
            n_fail++; $display("FAIL t1_level[%0d]: got %0d expected %0d", i, out_level, exp_lvl[i]);
         end
         n_checks++;
         if (out_phase !== exp_ph[i]) begin
            n_fail++; $display("FAIL t1_phase[%0d]: got %0d expected %0d", i, out_phase, exp_ph[i]);
         end
         n_checks++;
         if (period_done !== (i == 13)) begin
            n_fail++; $display("FAIL t1_pd[%0d]: got %b expected %b", i, period_done, (i == 13));
         end
         @(negedge clk);
      end
      n_checks++;
      if (busy !== 1'b0 || out_phase !== IDLE) begin
         n_fail++; $display("FAIL t1_end_idle: got busy=%b phase=%0d expected busy=0 phase=0", busy, out_phase);
      end
   endtask

   // Test 2: periodic, second period re-enters at RISE, period_done every 12 cycles.
   task automatic test_periodic();
      int         exp_lvl [14] = '{0, 0, 25, 50, 75, 100, 100, 100, 100, 50, 0, 0, 0, 0};
      seq_state_e exp_ph  [14] = '{DELAY, DELAY, RISE, RISE, RISE, RISE, HIGH, HIGH, HIGH,
                                   FALL, FALL, LOW, LOW, LOW};
      int k;
      int pd_cnt = 0;
      load_cfg(mk_cfg(2, 4, 3, 2, 3, 100, 25, 50, 1'b1));
      pulse_start();
      for (int i = 0; i < 26; i++) begin
         k = (i < 2) ? i : 2 + ((i - 2) % 12);
         n_checks++;
         if (out_phase !== exp_ph[k] || out_level !== AMP_W'(exp_lvl[k])) begin
            n_fail++;
            $display("FAIL t2_trace[%0d]: got phase=%0d level=%0d expected phase=%0d level=%0d",
                     i, out_phase, out_level, exp_ph[k], exp_lvl[k]);
         end
         n_checks++;
         if (period_done !== (k == 13)) begin
            n_fail++; $display("FAIL t2_pd[%0d]: got %b expected %b", i, period_done, (k == 13));
         end
         if (period_done === 1'b1) pd_cnt++;
         @(negedge clk);
      end
      n_checks++;
      if (out_phase !== RISE || out_level !== AMP_W'(25)) begin
         n_fail++; $display("FAIL t2_third_period: got phase=%0d level=%0d expected phase=2 level=25", out_phase, out_level);
      end
      n_checks++;
      if (pd_cnt != 2) begin n_fail++; $display("FAIL t2_pd_count: got %0d expected 2", pd_cnt); end
      do_stop();
   endtask

   // Test 3: zero-length ramps, level toggles every cycle with no dead cycles.
   task automatic test_zero_ramps();
      load_cfg(mk_cfg(0, 0, 1, 0, 1, 4095, 1, 1, 1'b1));
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (out_level !== ((i % 2 == 0) ? AMP_W'(4095) : AMP_W'(0)) ||
             out_phase !== ((i % 2 == 0) ? HIGH : LOW) ||
             period_done !== (i % 2 == 1)) begin
            n_fail++;
            $display("FAIL t3_toggle[%0d]: got level=%0d phase=%0d pd=%b", i, out_level, out_phase, period_done);
         end
         @(negedge clk);
      end
      do_stop();
      n_checks++;
      if (out_phase !== IDLE || out_level !== '0) begin
         n_fail++; $display("FAIL t3_stop: got phase=%0d level=%0d expected 0/0", out_phase, out_level);
      end
   endtask

   // Test 4: ramp saturation at amp and floor at zero, no wrap-around.
   task automatic test_saturation();
      int         exp_lvl [7] = '{3000, 4095, 4095, 4095, 0, 0, 0};
      seq_state_e exp_ph  [7] = '{RISE, RISE, RISE, HIGH, FALL, FALL, LOW};
      load_cfg(mk_cfg(0, 3, 1, 2, 1, 4095, 3000, 4095, 1'b0));
      pulse_start();
      for (int i = 0; i < 7; i++) begin
         n_checks++;
         if (out_level !== AMP_W'(exp_lvl[i]) || out_phase !== exp_ph[i]) begin
            n_fail++;
            $display("FAIL t4_sat[%0d]: got level=%0d phase=%0d expected level=%0d phase=%0d",
                     i, out_level, out_phase, exp_lvl[i], exp_ph[i]);
         end
         @(negedge clk);
      end
      n_checks++;
      if (out_phase !== IDLE) begin n_fail++; $display("FAIL t4_end: got phase=%0d expected 0", out_phase); end
   endtask

   // Test 5: stop in HIGH, start+stop together, async reset during RISE.
   task automatic test_stop_reset();
      load_cfg(mk_cfg(2, 4, 3, 2, 3, 100, 25, 50, 1'b0));
      pulse_start();
      repeat (6) @(negedge clk);
      n_checks++;
      if (out_phase !== HIGH) begin n_fail++; $display("FAIL t5_in_high: got %0d expected 3", out_phase); end
      do_stop();
      n_checks++;
      if (out_phase !== IDLE || out_level !== '0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL t5_stop_high: got phase=%0d level=%0d busy=%b expected 0/0/0", out_phase, out_level, busy);
      end
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (out_phase !== IDLE || busy !== 1'b0) begin
            n_fail++; $display("FAIL t5_start_stop[%0d]: got phase=%0d busy=%b expected 0/0", i, out_phase, busy);
         end
         @(negedge clk);
      end
      pulse_start();
      repeat (3) @(negedge clk);
      n_checks++;
      if (out_phase !== RISE || out_level !== AMP_W'(50)) begin
         n_fail++; $display("FAIL t5_in_rise: got phase=%0d level=%0d expected 2/50", out_phase, out_level);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_phase !== IDLE || out_level !== '0 || busy !== 1'b0 || cif.cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL t5_async_rst: got phase=%0d level=%0d busy=%b ready=%b expected 0/0/0/1",
                  out_phase, out_level, busy, cif.cfg_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      // Config was cleared: a start now runs the all-zero config, one HIGH cycle at level 0.
      pulse_start();
      n_checks++;
      if (out_phase !== HIGH || out_level !== '0 || period_done !== 1'b1) begin
         n_fail++;
         $display("FAIL t5_zero_cfg: got phase=%0d level=%0d pd=%b expected 3/0/1", out_phase, out_level, period_done);
      end
      @(negedge clk);
      n_checks++;
      if (out_phase !== IDLE) begin n_fail++; $display("FAIL t5_zero_cfg_end: got %0d expected 0", out_phase); end
   endtask

   // Test 6: config writes while busy are refused and the old config is kept.
   task automatic test_cfg_busy();
      load_cfg(mk_cfg(2, 4, 3, 2, 3, 100, 25, 50, 1'b0));
      pulse_start();
      n_checks++;
      if (cif.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL t6_ready_busy: got %b expected 0", cif.cfg_ready); end
      cif.cfg_valid = 1'b1;
      cif.cfg       = mk_cfg(0, 0, 2, 0, 0, 7, 7, 7, 1'b0);
      @(negedge clk);
      cif.cfg_valid = 1'b0;
      for (int i = 1; i < 14; i++) begin
         if (i == 5) begin
            n_checks++;
            if (out_level !== AMP_W'(100)) begin n_fail++; $display("FAIL t6_rise_top: got %0d expected 100", out_level); end
         end
         if (i == 7) begin
            n_checks++;
            if (out_phase !== HIGH || out_level !== AMP_W'(100)) begin
               n_fail++; $display("FAIL t6_high: got phase=%0d level=%0d expected 3/100", out_phase, out_level);
            end
         end
         @(negedge clk);
      end
      n_checks++;
      if (out_phase !== IDLE || cif.cfg_ready !== 1'b1) begin
         n_fail++; $display("FAIL t6_idle: got phase=%0d ready=%b expected 0/1", out_phase, cif.cfg_ready);
      end
      pulse_start();
      n_checks++;
      if (out_phase !== DELAY) begin n_fail++; $display("FAIL t6_cfg_kept: got phase=%0d expected 1", out_phase); end
      do_stop();
   endtask

`ifdef SEQ_BURST_COUNT_EN
   task automatic test_burst();
      seq_cfg_t c;
      int pd_cnt = 0;
      c       = mk_cfg(0, 0, 1, 0, 1, 4095, 1, 1, 1'b1);
      c.burst = CNT_W'(3);
      load_cfg(c);
      pulse_start();
      n_checks++;
      if (burst_left !== CNT_W'(3)) begin n_fail++; $display("FAIL t6_burst_load: got %0d expected 3", burst_left); end
      for (int i = 0; i < 10; i++) begin
         if (period_done === 1'b1) pd_cnt++;
         @(negedge clk);
      end
      n_checks++;
      if (pd_cnt != 3) begin n_fail++; $display("FAIL t6_burst_pd: got %0d expected 3", pd_cnt); end
      n_checks++;
      if (out_phase !== IDLE || burst_left !== '0) begin
         n_fail++; $display("FAIL t6_burst_end: got phase=%0d left=%0d expected 0/0", out_phase, burst_left);
      end
   endtask
`endif

   initial begin
      start         = 1'b0;
      stop          = 1'b0;
      cif.cfg_valid = 1'b0;
      cif.cfg       = '0;
      test_reset();
      test_one_shot();
      test_periodic();
      test_zero_ramps();
      test_saturation();
      test_stop_reset();
      test_cfg_busy();
`ifdef SEQ_BURST_COUNT_EN
      test_burst();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
